// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle.
// Master issues operations; slave returns registered results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] rem;
  logic             zero;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  y, rem, zero, busy, done, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output y, rem, zero, busy, done, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered multi-cycle execute-stage ALU.
// Single-cycle logic/arith ops plus iterative MUL and DIVU.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] rem_r;
  logic             zero_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;

  logic             is_iter;
  logic             last;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] res_y;
  logic [WIDTH-1:0] res_rem;
  logic             res_dz;

  assign bus.y        = y_r;
  assign bus.rem      = rem_r;
  assign bus.zero     = zero_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

  assign is_iter = (bus.op == OP_MUL) ||
                   ((bus.op == OP_DIVU) && (bus.b != '0));
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  // Restoring divide: a_q shifts out dividend bits and collects quotient bits
  assign shl   = {acc, a_q[WIDTH-1]};
  assign diff  = shl - {1'b0, b_q};
  assign q_bit = ~diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = is_iter ? ITER : FIN;
        end
      end
      ITER: begin
        if (last) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_y   = '0;
    res_rem = '0;
    res_dz  = 1'b0;
    unique case (op_q)
      OP_AND:  res_y = a_q & b_q;
      OP_OR:   res_y = a_q | b_q;
      OP_ADD:  res_y = a_q + b_q;
      OP_SUB:  res_y = a_q - b_q;
      OP_SLT:  res_y = {{(WIDTH-1){1'b0}},
                        $signed(a_q) < $signed(b_q)};
      OP_SLTU: res_y = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_MUL:  res_y = acc;
      OP_DIVU: begin
        if (b_q == '0) begin
          res_y   = '1;
          res_rem = a_q;
          res_dz  = 1'b1;
        end else begin
          res_y   = a_q;
          res_rem = acc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      cnt    <= '0;
      y_r    <= '0;
      rem_r  <= '0;
      zero_r <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            dz_r   <= 1'b0;
            busy_r <= is_iter;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) begin
            if (b_q[0]) begin
              acc <= acc + a_q;
            end
            a_q <= a_q << 1;
            b_q <= b_q >> 1;
          end else begin
            acc <= q_bit ? diff[WIDTH-1:0]
                         : shl[WIDTH-1:0];
            a_q <= {a_q[WIDTH-2:0], q_bit};
          end
        end
        FIN: begin
          y_r    <= res_y;
          rem_r  <= res_rem;
          zero_r <= (res_y == '0);
          dz_r   <= res_dz;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed plan plus
// randomized ops against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(input  logic [3:0]   op,
                                input  logic [W-1:0] a,
                                input  logic [W-1:0] b,
                                output logic [W-1:0] y,
                                output logic [W-1:0] rem,
                                output logic         dz,
                                output int           lat);
    y = '0;
    rem = '0;
    dz = 1'b0;
    lat = 2;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a + b;
      4'd6: y = a - b;
      4'd7: y = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8: y = (a < b) ? 1 : 0;
      4'd9: begin
        y = a * b;
        lat = W + 2;
      end
      4'd10: begin
        if (b == 0) begin
          y = '1;
          rem = a;
          dz = 1'b1;
        end else begin
          y = a / b;
          rem = a % b;
          lat = W + 2;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [3:0]   op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input string        tag,
                        input bit           poke);
    logic [W-1:0] ey;
    logic [W-1:0] er;
    logic         edz;
    int           elat;
    int           lat;
    int           bcnt;
    model(op, a, b, ey, er, edz, elat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op = 4'($urandom);
    bus.a = $urandom;
    bus.b = $urandom;
    lat = 1;
    bcnt = bus.busy ? 1 : 0;
    while (!bus.done && lat < 200) begin
      if (poke && lat == 5) begin
        bus.start = 1'b1;
        bus.op = 4'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) bcnt++;
    end
    bus.start = 1'b0;
    check($sformatf("%s lat", tag), lat, elat);
    check($sformatf("%s busy_cycles", tag), bcnt,
          (elat == 2) ? 0 : W + 1);
    check($sformatf("%s y", tag), bus.y, ey);
    check($sformatf("%s rem", tag), bus.rem, er);
    check($sformatf("%s zero", tag), bus.zero, ey == 0);
    check($sformatf("%s div_zero", tag), bus.div_zero, edz);
    check($sformatf("%s busy_at_done", tag), bus.busy, 1'b0);
  endtask

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bus.start = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst y", bus.y, 0);
    check("rst rem", bus.rem, 0);
    check("rst zero", bus.zero, 1);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst div_zero", bus.div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd6, 32'h29, 32'h08, "sub", 0);
    run_op(4'd0, 32'h29, 32'h08, "and", 0);
    run_op(4'd1, 32'h29, 32'h08, "or", 0);
    run_op(4'd2, 32'h29, 32'h08, "add", 0);
    run_op(4'd6, 32'h08, 32'h08, "sub_eq", 0);
    run_op(4'd7, 32'hFFFFFFFD, 32'hFFFFFFFB, "slt_a", 0);
    run_op(4'd7, 32'hFFFFFFFB, 32'hFFFFFFFD, "slt_b", 0);
    run_op(4'd7, 32'h1, 32'hFFFFFFFF, "slt_c", 0);
    run_op(4'd8, 32'h1, 32'hFFFFFFFF, "sltu_c", 0);
    run_op(4'd9, 32'h0000FFFF, 32'h00010001, "mul_a", 0);
    run_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, "mul_b", 1);
    run_op(4'd10, 32'd100, 32'd7, "divu_a", 0);
    run_op(4'd10, 32'd7, 32'd100, "divu_b", 0);
    run_op(4'd10, 32'hFFFFFFFF, 32'd1, "divu_c", 0);
    run_op(4'd10, 32'h12345678, 32'd0, "div0", 0);
    run_op(4'd2, 32'd1, 32'd1, "after_div0", 0);
    run_op(4'd13, 32'h55, 32'h66, "bad_op", 0);

    run_op(4'd2, 32'h1234, 32'h1, "pre_rst", 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 4'd9;
    bus.a = 32'hFFFF;
    bus.b = 32'h3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst y", bus.y, 0);
    check("midrst zero", bus.zero, 1);
    check("midrst busy", bus.busy, 0);
    check("midrst done", bus.done, 0);
    check("midrst rem", bus.rem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd2, 32'd3, 32'd4, "post_rst_add", 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: rop = 4'd0;
        1: rop = 4'd1;
        2: rop = 4'd2;
        3: rop = 4'd6;
        4: rop = 4'd7;
        5: rop = 4'd8;
        6: rop = 4'd9;
        7: rop = 4'd10;
        default: rop = 4'($urandom);
      endcase
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) rb = '0;
      run_op(rop, ra, rb, $sformatf("rnd%0d_op%0d", i, rop), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
